sample_replay_ctrl: RTL and testbench

Sequencer that replays stored 1-bit GPS IF samples from the sample RAM into the Costas loop and schedules capture of the loop's decimated output into the capture RAM. It generates the sample-RAM read address over a configurable window, repeats the window a configurable number of times, holds the Costas loop in reset while idle, and produces capture-RAM write strobes and addresses from the 10 kHz enable. It replaces free-running address counters with a start/abort/done handshake usable by both testbenches and on-chip control.

---
 rtl/gps_ctrl_pkg.sv | 14 +
 rtl/capture_addr_gen.sv | 45 ++++
 rtl/sample_replay_ctrl.sv | 123 ++++++++++++
 tb/tb_sample_replay_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gps_ctrl_pkg.sv
// Shared types and defaults for the GPS replay/capture control path.
package gps_ctrl_pkg;
    localparam int ADDR_W_DEF = 22;
    localparam int CAP_AW_DEF = 12;
    localparam int LOOP_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } replay_state_t;
endpackage

// File: rtl/capture_addr_gen.sv
// Turns the 10 kHz enable into capture-RAM write strobes and a saturating address.
module capture_addr_gen
    import gps_ctrl_pkg::*;
#(
    parameter int CAP_AW = CAP_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              ce_10k,
    output logic              cap_we,
    output logic [CAP_AW-1:0] cap_addr,
    output logic              cap_full,
    output logic              cap_overflow
);
    logic last_addr;
    logic full_eff;

    assign last_addr = (cap_addr == {CAP_AW{1'b1}});
    // A write to the last slot still in flight already counts as full.
    assign full_eff  = cap_full || (cap_we && last_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_full     <= 1'b0;
            cap_overflow <= 1'b0;
        end else if (clear) begin
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_full     <= 1'b0;
            cap_overflow <= 1'b0;
        end else begin
            cap_we <= enable && ce_10k && !full_eff;
            if (enable && ce_10k && full_eff)
                cap_overflow <= 1'b1;
            if (cap_we) begin
                if (last_addr) cap_full <= 1'b1;
                else           cap_addr <= cap_addr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sample_replay_ctrl.sv
// Replays a sample-RAM window a set number of times and schedules capture writes.
module sample_replay_ctrl
    import gps_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CAP_AW = CAP_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [ADDR_W-1:0] cfg_end_addr,
    input  logic [7:0]        cfg_loops,
    input  logic              ce_10k,
    output logic [ADDR_W-1:0] ram_address,
    output logic              sample_valid,
    output logic              loop_rst,
    output logic              cap_we,
    output logic [CAP_AW-1:0] cap_addr,
    output logic              cap_full,
    output logic              cap_overflow,
    output logic [7:0]        loop_count,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    replay_state_t     state, state_n;
    logic [ADDR_W-1:0] s_q, e_q, s_n, e_n, addr_n;
    logic [LOOP_W-1:0] loops_q, loops_n, lc_n, lc_inc;
    logic              err_n, cap_clr, cap_en, issuing, final_pass;

    assign lc_inc     = loop_count + LOOP_W'(1);
    // loops_q == 0 means run forever, so the wrap of lc_inc to 0 must not end it.
    assign final_pass = (lc_inc == loops_q) && (loops_q != '0);
    assign issuing    = (state == ST_ARM) || (state == ST_RUN);
    assign cap_en     = ((state == ST_RUN) || (state == ST_DRAIN)) && !abort;

    always_comb begin
        state_n = state;
        addr_n  = ram_address;
        lc_n    = loop_count;
        s_n     = s_q;
        e_n     = e_q;
        loops_n = loops_q;
        err_n   = 1'b0;
        cap_clr = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                if (cfg_end_addr < cfg_start_addr) begin
                    err_n = 1'b1;
                end else begin
                    s_n     = cfg_start_addr;
                    e_n     = cfg_end_addr;
                    loops_n = cfg_loops;
                    addr_n  = cfg_start_addr;
                    lc_n    = '0;
                    cap_clr = 1'b1;
                    state_n = ST_ARM;
                end
            end
            ST_ARM, ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (ram_address != e_q) begin
                    addr_n  = ram_address + 1'b1;
                    state_n = ST_RUN;
                end else if (final_pass) begin
                    lc_n    = lc_inc;
                    state_n = ST_DRAIN;
                end else begin
                    addr_n  = s_q;
                    lc_n    = lc_inc;
                    state_n = ST_RUN;
                end
            end
            ST_DRAIN: state_n = abort ? ST_IDLE : ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            s_q          <= '0;
            e_q          <= '0;
            loops_q      <= '0;
            ram_address  <= '0;
            loop_count   <= '0;
            sample_valid <= 1'b0;
            loop_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_n;
            s_q          <= s_n;
            e_q          <= e_n;
            loops_q      <= loops_n;
            ram_address  <= addr_n;
            loop_count   <= lc_n;
            // RAM read latency is one cycle, so valid trails the issue state.
            sample_valid <= issuing && !abort;
            loop_rst     <= !((state_n == ST_ARM) || (state_n == ST_RUN) || (state_n == ST_DRAIN));
            busy         <= (state_n != ST_IDLE);
            done         <= (state == ST_DRAIN) && !abort;
            cfg_err      <= err_n;
        end
    end

    capture_addr_gen #(.CAP_AW(CAP_AW)) u_cap (
        .clk          (CLK),
        .rst          (RST),
        .clear        (cap_clr),
        .enable       (cap_en),
        .ce_10k       (ce_10k),
        .cap_we       (cap_we),
        .cap_addr     (cap_addr),
        .cap_full     (cap_full),
        .cap_overflow (cap_overflow)
    );
endmodule

// File: tb/tb_sample_replay_ctrl.sv
// Table-driven and randomized bench for sample_replay_ctrl against a cycle-index model.
module tb_sample_replay_ctrl;
    localparam int AW = 22;
    localparam int CW = 3;
    localparam int CAP_DEPTH = 1 << CW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start, abort, ce_10k;
    logic [AW-1:0] cfg_start_addr, cfg_end_addr;
    logic [7:0]    cfg_loops;
    logic [AW-1:0] ram_address, ram_data;
    logic          sample_valid, loop_rst, cap_we, cap_full, cap_overflow, busy, done, cfg_err;
    logic [CW-1:0] cap_addr;
    logic [7:0]    loop_count;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int s; int e; int loops;
        int ce_per; int ce_off;       // ce_per: -1 none, 0 random, else period
        int abort_at; int restart_at; // -1 = never
        int cycles;                   // 0 = full run plus settle
        int exp_lc; int exp_ovf;      // final loop_count / overflow, exp_ovf -1 = skip
    } vec_t;

    sample_replay_ctrl #(.ADDR_W(AW), .CAP_AW(CW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr), .cfg_loops(cfg_loops),
        .ce_10k(ce_10k), .ram_address(ram_address), .sample_valid(sample_valid),
        .loop_rst(loop_rst), .cap_we(cap_we), .cap_addr(cap_addr), .cap_full(cap_full),
        .cap_overflow(cap_overflow), .loop_count(loop_count), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    // Sample RAM stand-in: content equals address, one-cycle read latency.
    always_ff @(posedge CLK) ram_data <= ram_address;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_addr"}, ram_address, 0);
        chk({nm, "_sv"}, sample_valid, 0);
        chk({nm, "_lrst"}, loop_rst, 1);
        chk({nm, "_we"}, cap_we, 0);
        chk({nm, "_caddr"}, cap_addr, 0);
        chk({nm, "_full"}, cap_full, 0);
        chk({nm, "_ovf"}, cap_overflow, 0);
        chk({nm, "_lc"}, loop_count, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, cfg_err, 0);
    endtask

    // Cycle j = the cycle following the edge that accepted start (j=0 is ARM).
    task automatic run_case(input vec_t v);
        int  n, t, cyc, req, wr, q, lcj;
        bit  pend, ovf, aborted, active, ce;
        n   = v.e - v.s + 1;
        t   = (v.loops == 0) ? (1 << 30) : n * v.loops;
        cyc = (v.cycles != 0) ? v.cycles : t + 3;
        cfg_start_addr = AW'(v.s);
        cfg_end_addr   = AW'(v.e);
        cfg_loops      = 8'(v.loops);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        req = 0; wr = 0; pend = 1'b0; ovf = 1'b0;
        for (int j = 0; j < cyc; j++) begin
            aborted = (v.abort_at >= 0) && (j > v.abort_at);
            lcj = aborted ? v.abort_at : j;
            q = lcj / n;
            if (v.loops != 0 && q > v.loops) q = v.loops;
            if (v.loops == 0) q = q % 256;
            chk("sample_valid", sample_valid, !aborted && j >= 1 && j <= t);
            chk("busy", busy, !aborted && j <= t + 1);
            chk("loop_rst", loop_rst, aborted || j > t);
            chk("done", done, !aborted && j == t + 1);
            chk("cfg_err", cfg_err, 0);
            chk("loop_count", loop_count, q);
            chk("cap_we", cap_we, pend);
            chk("cap_addr", cap_addr, (wr >= CAP_DEPTH) ? CAP_DEPTH - 1 : wr);
            chk("cap_full", cap_full, wr >= CAP_DEPTH);
            chk("cap_overflow", cap_overflow, ovf);
            if (j == 0) chk("first_addr", ram_address, v.s);
            if (!aborted && j >= 1 && j <= t) chk("ram_data", ram_data, v.s + (j - 1) % n);
            // capture model: requests in active cycles, write visible one cycle later
            if (pend) wr++;
            active = j >= 1 && j <= t && !(v.abort_at >= 0 && j >= v.abort_at);
            if (v.ce_per < 0)       ce = 1'b0;
            else if (v.ce_per == 0) ce = ($urandom_range(0, 4) == 0);
            else                    ce = ((j % v.ce_per) == v.ce_off);
            pend = 1'b0;
            if (ce && active) begin
                if (req < CAP_DEPTH) begin req++; pend = 1'b1; end
                else ovf = 1'b1;
            end
            ce_10k = ce;
            abort  = (j == v.abort_at);
            start  = (j == v.restart_at);
            if (j == v.restart_at) cfg_start_addr = AW'(v.s + 3);
            @(negedge CLK);
        end
        ce_10k = 1'b0; abort = 1'b0; start = 1'b0;
        chk("final_lc", loop_count, v.exp_lc);
        if (v.exp_ovf >= 0) chk("final_ovf", cap_overflow, v.exp_ovf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t rv;
        bit   found;
        tbl[0] = '{0,   9,   1, -1, 0, -1, -1, 0,   1, 0};
        tbl[1] = '{5,   7,   3,  4, 1, -1,  4, 0,   3, 0};
        tbl[2] = '{0,   99,  0,  7, 2, 250, -1, 256, 2, 1};
        tbl[3] = '{100, 199, 1, 10, 3, -1, -1, 0,   1, 1};
        tbl[4] = '{42,  42,  4, -1, 0, -1, -1, 0,   4, 0};
        tbl[5] = '{0,   3,   2, -1, 0,  8, -1, 14,  2, 0};
        tbl[6] = '{20,  30,  1,  1, 0,  0, -1, 5,   0, 0};
        tbl[7] = '{7,   7,   0, -1, 0, 300, -1, 305, 44, 0};

        RST = 1'b1; start = 1'b0; abort = 1'b0; ce_10k = 1'b0;
        cfg_start_addr = '0; cfg_end_addr = '0; cfg_loops = '0;
        repeat (2) @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b0;
        @(negedge CLK);

        // rejected configuration: E < S
        cfg_start_addr = 22'd10; cfg_end_addr = 22'd3; cfg_loops = 8'd1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("err_pulse", cfg_err, 1);
        chk("err_busy", busy, 0);
        @(negedge CLK);
        chk("err_clear", cfg_err, 0);
        chk("err_busy2", busy, 0);

        for (int i = 0; i < 8; i++) run_case(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            rv.s = int'($urandom_range(0, (1 << AW) - 64));
            rv.e = rv.s + int'($urandom_range(0, 19));
            rv.loops = int'($urandom_range(1, 3));
            rv.ce_per = 0; rv.ce_off = 0;
            rv.abort_at = -1; rv.restart_at = int'($urandom_range(1, 5));
            rv.cycles = 0; rv.exp_lc = rv.loops; rv.exp_ovf = -1;
            run_case(rv);
        end

        // asynchronous reset in the middle of a run
        cfg_start_addr = 22'h12340; cfg_end_addr = 22'h123FF; cfg_loops = 8'd1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ram_address == 22'h12345) found = 1'b1;
            else @(negedge CLK);
        end
        chk("rst_reach_addr", found, 1);
        #2 RST = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        rv = '{12288, 12292, 2, 3, 1, -1, -1, 0, 2, 0};
        run_case(rv);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
